// File: rtl/dmem_arbiter.sv
// Purpose : shares single-port dmem between pipeline port A (priority) and secondary master B.
// Latency : grant is combinational (0 cycles); read data returns 1 cycle after grant, no buffering.
// Backpress: A sees a_stall when B takes the slot; B holds b_req until b_gnt (may abandon).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   a_read/a_writeb/a_addr/a_wdata  port A request (A active = read or any byte enable)
//   a_stall, a_rvalid             A denied this cycle / dmem_rdata belongs to A's previous load
//   b_req/b_read/b_writeb/b_addr/b_wdata  port B request, sampled on the b_gnt cycle
//   b_gnt, b_rvalid, b_rdata      B accepted / B read data valid / B read data
//   dmem_*                        single-port data memory, registered read data
module dmem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_read,
  input  logic [3:0]        a_writeb,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_stall,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_read,
  input  logic [3:0]        b_writeb,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,
  output logic              dmem_read,
  output logic [3:0]        dmem_writeb,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata
);

  logic [CNT_W-1:0] starve_cnt;
  logic             a_act;
  logic             force_b;
  logic             gnt_a;
  logic             gnt_b;

  // Grants are gated by rst so nothing reaches dmem while in reset.
  always_comb begin
    a_act   = a_read | (|a_writeb);
    force_b = (starve_cnt == CNT_W'(STARVE_LIMIT));
    gnt_b   = ~rst & b_req & (~a_act | force_b);
    gnt_a   = ~rst & a_act & ~gnt_b;
  end

  assign b_gnt   = gnt_b;
  assign a_stall = a_act & gnt_b;
  // A consumes dmem_rdata directly; B gets its own copy qualified by b_rvalid.
  assign b_rdata = dmem_rdata;

  // When nobody is granted, addr/wdata follow A but no access is issued.
  always_comb begin
    dmem_read   = 1'b0;
    dmem_writeb = 4'b0000;
    dmem_addr   = a_addr;
    dmem_wdata  = a_wdata;
    if (gnt_b) begin
      dmem_read   = b_read;
      dmem_writeb = b_read ? 4'b0000 : b_writeb;
      dmem_addr   = b_addr;
      dmem_wdata  = b_wdata;
    end else if (gnt_a) begin
      dmem_read   = a_read;
      dmem_writeb = a_writeb;
    end
  end

  // The counter restarts at 0 after a forced grant, so A then gets at least
  // STARVE_LIMIT uncontested cycles before B can be forced in again.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
    end else begin
      if (gnt_b || !b_req) begin
        starve_cnt <= '0;
      end else if (!force_b) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
      a_rvalid <= gnt_a & a_read;
      b_rvalid <= gnt_b & b_read;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_read;
  logic [3:0]  a_writeb;
  logic [10:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_stall;
  logic        a_rvalid;
  logic        b_req;
  logic        b_read;
  logic [3:0]  b_writeb;
  logic [10:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_gnt;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic        dmem_read;
  logic [3:0]  dmem_writeb;
  logic [10:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  logic [31:0] mem [0:2047];
  logic        mem_init;

  int total = 0;
  int bad   = 0;
  logic [31:0] aq[$];
  logic [31:0] bq[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(11), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .a_read(a_read), .a_writeb(a_writeb), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_stall(a_stall), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_read(b_read), .b_writeb(b_writeb), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .dmem_read(dmem_read), .dmem_writeb(dmem_writeb), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  // Single-port memory: registered read, byte-lane writes. Word i starts as C0DE_0000|i.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else begin
      if (dmem_read) dmem_rdata <= mem[dmem_addr];
      for (int k = 0; k < 4; k++)
        if (dmem_writeb[k]) mem[dmem_addr][8*k +: 8] <= dmem_wdata[8*k +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    a_read = 0; a_writeb = 4'b0; a_addr = 11'h0; a_wdata = 32'h0;
    b_req = 0; b_read = 0; b_writeb = 4'b0; b_addr = 11'h0; b_wdata = 32'h0;
  endtask

  // Monitor: pops expected read data whenever an rvalid is presented.
  always @(negedge clk) begin
    if (!mem_init) begin
      chk("rvalid_excl", {31'b0, a_rvalid & b_rvalid}, 32'h0);
      if (b_rvalid) begin
        if (bq.size() == 0) chk("b_rvalid_unexp", {31'b0, b_rvalid}, 32'h0);
        else chk("b_rdata", b_rdata, bq.pop_front());
      end
      if (a_rvalid) begin
        if (aq.size() == 0) chk("a_rvalid_unexp", {31'b0, a_rvalid}, 32'h0);
        else chk("a_rdata", dmem_rdata, aq.pop_front());
      end
    end
  end

  initial begin
    logic e;
    rst = 1; mem_init = 1; idle();
    next();
    mem_init = 0;
    // requests presented during reset must be ignored
    a_read = 1; b_req = 1; b_read = 1;
    mid();
    chk("rst_b_gnt", {31'b0, b_gnt}, 0);
    chk("rst_a_stall", {31'b0, a_stall}, 0);
    chk("rst_dmem_read", {31'b0, dmem_read}, 0);
    chk("rst_dmem_writeb", {28'b0, dmem_writeb}, 0);
    next();
    rst = 0; idle();
    mid();
    chk("rst_a_rvalid", {31'b0, a_rvalid}, 0);
    chk("rst_b_rvalid", {31'b0, b_rvalid}, 0);
    next();

    // T1: A idle, B load 0x010
    b_req = 1; b_read = 1; b_addr = 11'h010;
    mid();
    chk("t1_b_gnt", {31'b0, b_gnt}, 1);
    chk("t1_dmem_read", {31'b0, dmem_read}, 1);
    chk("t1_dmem_addr", {21'b0, dmem_addr}, 32'h010);
    bq.push_back(32'hC0DE_0010);
    next();
    idle();
    mid();
    chk("t1_b_rvalid", {31'b0, b_rvalid}, 1);
    next();

    // T2: A load every cycle, B held: forced grant on cycles 4 and 9
    a_read = 1; a_addr = 11'h020;
    b_req = 1; b_read = 1; b_addr = 11'h030;
    for (int i = 0; i < 10; i++) begin
      mid();
      e = (i == 4) || (i == 9);
      chk($sformatf("t2_b_gnt_%0d", i), {31'b0, b_gnt}, {31'b0, e});
      chk($sformatf("t2_a_stall_%0d", i), {31'b0, a_stall}, {31'b0, e});
      if (e) bq.push_back(32'hC0DE_0030);
      else   aq.push_back(32'hC0DE_0020);
      next();
    end
    b_req = 0;
    mid();
    chk("t2_retry_stall", {31'b0, a_stall}, 0);
    aq.push_back(32'hC0DE_0020);
    next();
    idle();

    // T3: forced B store 0x55 and A store 0xAA to the same byte; A must win
    a_read = 1; a_addr = 11'h050;
    b_req = 1; b_read = 0; b_writeb = 4'b0001; b_addr = 11'h040; b_wdata = 32'h0000_0055;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("t3_b_gnt_%0d", i), {31'b0, b_gnt}, 0);
      aq.push_back(32'hC0DE_0050);
      next();
    end
    a_read = 0; a_writeb = 4'b0001; a_addr = 11'h040; a_wdata = 32'h0000_00AA;
    mid();
    chk("t3_force_gnt", {31'b0, b_gnt}, 1);
    chk("t3_force_stall", {31'b0, a_stall}, 1);
    chk("t3_b_wdata", dmem_wdata, 32'h0000_0055);
    chk("t3_b_writeb", {28'b0, dmem_writeb}, 32'h1);
    next();
    b_req = 0;
    mid();
    chk("t3_mid_word", mem[11'h040], 32'hC0DE_0055);
    chk("t3_a_stall", {31'b0, a_stall}, 0);
    chk("t3_a_wdata", dmem_wdata, 32'h0000_00AA);
    next();
    idle();
    mid();
    chk("t3_final_word", mem[11'h040], 32'hC0DE_00AA);
    next();

    // T4: B store, writeb 1100, A idle
    b_req = 1; b_read = 0; b_writeb = 4'b1100; b_addr = 11'h005; b_wdata = 32'hDEAD_0000;
    mid();
    chk("t4_b_gnt", {31'b0, b_gnt}, 1);
    chk("t4_dmem_read", {31'b0, dmem_read}, 0);
    chk("t4_dmem_writeb", {28'b0, dmem_writeb}, 32'hC);
    next();
    idle();
    mid();
    chk("t4_b_rvalid", {31'b0, b_rvalid}, 0);
    chk("t4_word", mem[11'h005], 32'hDEAD_0005);
    next();

    // T5: B abandons after 2 denied cycles; re-request needs 4 more denials
    a_read = 1; a_addr = 11'h060;
    b_read = 1; b_addr = 11'h070;
    for (int i = 0; i < 9; i++) begin
      b_req = (i != 2);
      mid();
      e = (i == 7);
      chk($sformatf("t5_b_gnt_%0d", i), {31'b0, b_gnt}, {31'b0, e});
      if (e) bq.push_back(32'hC0DE_0070);
      else   aq.push_back(32'hC0DE_0060);
      next();
    end
    idle();
    mid();
    next();

    // T6a: reset while a B read return is in flight
    b_req = 1; b_read = 1; b_addr = 11'h010;
    mid();
    chk("t6_b_gnt", {31'b0, b_gnt}, 1);
    bq.push_back(32'hC0DE_0010);
    next();
    idle(); rst = 1;
    mid();
    next();
    rst = 0;
    mid();
    chk("t6_b_rvalid", {31'b0, b_rvalid}, 0);
    chk("t6_a_rvalid", {31'b0, a_rvalid}, 0);
    next();

    // T6b: reset with starve count at 3 must restart the count
    a_read = 1; a_addr = 11'h060;
    b_req = 1; b_read = 1; b_addr = 11'h070;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("t6_pre_gnt_%0d", i), {31'b0, b_gnt}, 0);
      aq.push_back(32'hC0DE_0060);
      next();
    end
    rst = 1;
    mid();
    chk("t6_rst_b_gnt", {31'b0, b_gnt}, 0);
    chk("t6_rst_a_stall", {31'b0, a_stall}, 0);
    chk("t6_rst_dmem_read", {31'b0, dmem_read}, 0);
    next();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      mid();
      e = (i == 4);
      chk($sformatf("t6_post_gnt_%0d", i), {31'b0, b_gnt}, {31'b0, e});
      if (e) bq.push_back(32'hC0DE_0070);
      else   aq.push_back(32'hC0DE_0060);
      next();
    end
    idle();
    mid();
    next();
    mid();
    chk("aq_drained", aq.size(), 0);
    chk("bq_drained", bq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
